// File: rtl/axi_ram_responder.sv
// axi_ram_responder: AXI4 slave on on-chip RAM; write AW/W/B and read AR/R engines are independent, ports clk/rst plus s_axi_* (lock/cache/prot/qos ignored)
module axi_ram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  localparam int LSB   = $clog2(STRB_WIDTH);
  localparam int WORDS = 2 ** (ADDR_WIDTH - LSB);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                                      input logic [2:0] size, input logic [1:0] burst);
    logic [2:0] sz;
    logic [ADDR_WIDTH-1:0] incr, mask;
    sz   = (size > 3'(LSB)) ? 3'(LSB) : size;
    incr = ADDR_WIDTH'(1) << sz;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
    return burst == 2'b00 ? addr : burst == 2'b10 ? ((addr & ~mask) | ((addr + incr) & mask)) : addr + incr;
  endfunction
  logic [DATA_WIDTH-1:0] mem [WORDS];
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic                  w_err_q, w_err_d;
  logic                  aw_fire, w_fire, b_fire, w_last;
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d, rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]            ar_len_q, ar_len_d;
  logic [8:0]            r_cnt_q, r_cnt_d;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ar_fire, r_fire, r_issue;
  logic                  unused_sideband;
  assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
  assign s_axi_awready = (w_state_q == W_IDLE) && !rst;
  assign s_axi_wready  = w_state_q == W_DATA;
  assign s_axi_bvalid  = w_state_q == W_RESP;
  assign s_axi_bid     = aw_id_q;
  assign s_axi_bresp   = {w_err_q, 1'b0};
  assign aw_fire       = s_axi_awvalid && s_axi_awready;
  assign w_fire        = s_axi_wvalid && s_axi_wready;
  assign b_fire        = s_axi_bvalid && s_axi_bready;
  assign w_last        = w_cnt_q == aw_len_q;
  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_fire ? s_axi_awid : aw_id_q;
    aw_len_d   = aw_fire ? s_axi_awlen : aw_len_q;
    aw_size_d  = aw_fire ? s_axi_awsize : aw_size_q;
    aw_burst_d = aw_fire ? s_axi_awburst : aw_burst_q;
    aw_addr_d  = aw_fire ? s_axi_awaddr : w_fire ? next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q) : aw_addr_q;
    w_cnt_d    = aw_fire ? 8'd0 : w_fire ? w_cnt_q + 8'd1 : w_cnt_q;
    w_err_d    = aw_fire ? 1'b0 : w_err_q | (w_fire && (s_axi_wlast != w_last));
    if (aw_fire) w_state_d = W_DATA;
    if (w_fire && w_last) w_state_d = W_RESP;
    if (b_fire) w_state_d = W_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (w_fire && !rst)
      for (int b = 0; b < STRB_WIDTH; b++)
        if (s_axi_wstrb[b]) mem[aw_addr_q[ADDR_WIDTH-1:LSB]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
  end
  assign s_axi_arready = (r_state_q == R_IDLE) && !rst;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign ar_fire       = s_axi_arvalid && s_axi_arready;
  assign r_fire        = rvalid_q && s_axi_rready;
  // The RAM read lands directly in the output register, so a new beat may issue whenever that register frees up.
  assign r_issue       = (r_state_q == R_DATA) && (r_cnt_q <= {1'b0, ar_len_q}) && (!rvalid_q || s_axi_rready);
  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_fire ? s_axi_arid : ar_id_q;
    ar_len_d   = ar_fire ? s_axi_arlen : ar_len_q;
    ar_size_d  = ar_fire ? s_axi_arsize : ar_size_q;
    ar_burst_d = ar_fire ? s_axi_arburst : ar_burst_q;
    ar_addr_d  = ar_fire ? s_axi_araddr : r_issue ? next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q) : ar_addr_q;
    r_cnt_d    = ar_fire ? 9'd0 : r_issue ? r_cnt_q + 9'd1 : r_cnt_q;
    rvalid_d   = r_issue ? 1'b1 : r_fire ? 1'b0 : rvalid_q;
    rlast_d    = r_issue ? (r_cnt_q[7:0] == ar_len_q) : r_fire ? 1'b0 : rlast_q;
    rid_d      = r_issue ? ar_id_q : rid_q;
    if (ar_fire) r_state_d = R_DATA;
    if (r_fire && rlast_q) r_state_d = R_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (r_issue) rdata_q <= mem[ar_addr_q[ADDR_WIDTH-1:LSB]];
  end
endmodule

// File: tb/tb_axi_ram_responder.sv
// tb_axi_ram_responder: directed and randomized bursts checked against a word-array model of the RAM
module tb_axi_ram_responder;
  logic        clk, rst;
  logic [7:0]  s_axi_awid, s_axi_awlen, s_axi_bid, s_axi_arid, s_axi_arlen, s_axi_rid;
  logic [15:0] s_axi_awaddr, s_axi_araddr;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [31:0] model [0:16383];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rbeat [256];
  int          tests = 0;
  int          fails = 0;
  axi_ram_responder dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
    .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
    .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // Address of beat i computed from the burst's footprint: a fixed word, a linear run, or a ring of span bytes.
  function automatic logic [15:0] beat_addr(input logic [15:0] start, input logic [7:0] len, input logic [2:0] size,
                                            input logic [1:0] burst, input int i);
    int incr, span, off;
    incr = 1 << ((size > 3'd2) ? 2 : int'(size));
    span = (int'(len) + 1) * incr;
    off  = int'(start) % span;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) return 16'(int'(start) - off + (off + i * incr) % span);
    return 16'(int'(start) + i * incr);
  endfunction
  task automatic axi_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int err_beat, input int bdelay);
    int n;
    logic [15:0] a;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(posedge clk); #1; n++; end
    check("aw_ready_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin s_axi_wvalid = 1'b0; @(posedge clk); #1; end
      s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
      s_axi_wlast = (i == int'(len)) ^ (i == err_beat);
      n = 0;
      while (!s_axi_wready && n < 50) begin @(posedge clk); #1; n++; end
      check("w_ready_wait", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      a = beat_addr(addr, len, size, burst, i);
      for (int b = 0; b < 4; b++) if (ws[i][b]) model[a[15:2]][8*b +: 8] = wd[i][8*b +: 8];
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("b_valid_wait", 32'(n < 50), 32'd1);
    for (int k = 0; k < bdelay; k++) begin
      check("b_hold_valid", 32'(s_axi_bvalid), 32'd1);
      check("b_hold_awready", 32'(s_axi_awready), 32'd0);
      check("b_hold_bid", 32'(s_axi_bid), 32'(id));
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b1;
    check("b_valid", 32'(s_axi_bvalid), 32'd1);
    check("b_id", 32'(s_axi_bid), 32'(id));
    check("b_resp", 32'(s_axi_bresp), (err_beat >= 0) ? 32'd2 : 32'd0);
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check("b_valid_drop", 32'(s_axi_bvalid), 32'd0);
    check("aw_ready_back", 32'(s_axi_awready), 32'd1);
  endtask
  // mode 0: rready held high, 1: rready toggles every cycle, 2: random rready
  task automatic axi_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int mode);
    int n, c, beat, first;
    logic stalled;
    logic [31:0] hold;
    logic [15:0] a;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(posedge clk); #1; n++; end
    check("ar_ready_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    c = 0; beat = 0; first = -1; stalled = 1'b0; hold = '0;
    while (beat <= int'(len) && c < 3000) begin
      if (stalled) begin
        check("r_stall_valid", 32'(s_axi_rvalid), 32'd1);
        check("r_stall_data", s_axi_rdata, hold);
      end
      if (s_axi_rvalid && first < 0) first = c;
      s_axi_rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2) : 1'($urandom_range(0, 1));
      if (s_axi_rvalid && s_axi_rready) begin
        a = beat_addr(addr, len, size, burst, beat);
        rbeat[beat] = s_axi_rdata;
        check("r_data", s_axi_rdata, model[a[15:2]]);
        check("r_last", 32'(s_axi_rlast), 32'(beat == int'(len)));
        check("r_id", 32'(s_axi_rid), 32'(id));
        check("r_resp", 32'(s_axi_rresp), 32'd0);
        beat++;
      end
      stalled = s_axi_rvalid && !s_axi_rready;
      hold = s_axi_rdata;
      @(posedge clk); #1;
      c++;
    end
    s_axi_rready = 1'b0;
    check("r_beat_count", 32'(beat), 32'(int'(len) + 1));
    if (mode == 0) check("r_first_latency", 32'(first + 1), 32'd2);
    check("r_valid_after", 32'(s_axi_rvalid), 32'd0);
    check("ar_ready_back", 32'(s_axi_arready), 32'd1);
  endtask
  initial begin
    logic [2:0] sz;
    logic [1:0] bu;
    logic [7:0] ln;
    logic [15:0] ad;
    int eb;
    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_wready", 32'(s_axi_wready), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_rlast", 32'(s_axi_rlast), 32'd0);
    check("rst_bid", 32'(s_axi_bid), 32'd0);
    check("rst_rid", 32'(s_axi_rid), 32'd0);
    check("rst_bresp", 32'(s_axi_bresp), 32'd0);
    check("rst_rresp", 32'(s_axi_rresp), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_awready", 32'(s_axi_awready), 32'd1);
    check("idle_arready", 32'(s_axi_arready), 32'd1);
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(8'h01, 16'h0000, 8'd255, 3'd2, 2'b01, -1, 0);
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    axi_write(8'h5A, 16'h0100, 8'd3, 3'd2, 2'b01, -1, 0);
    axi_read(8'h33, 16'h0100, 8'd3, 3'd2, 2'b01, 0);
    check("incr_beat0", rbeat[0], 32'h11);
    check("incr_beat3", rbeat[3], 32'h44);
    axi_read(8'h34, 16'h0108, 8'd3, 3'd2, 2'b10, 0);
    check("wrap_beat0", rbeat[0], 32'h33);
    check("wrap_beat1", rbeat[1], 32'h44);
    check("wrap_beat2", rbeat[2], 32'h11);
    check("wrap_beat3", rbeat[3], 32'h22);
    wd[0] = 32'h0; ws[0] = 4'hF;
    axi_write(8'h02, 16'h0000, 8'd0, 3'd2, 2'b01, -1, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    axi_write(8'h03, 16'h0000, 8'd0, 3'd2, 2'b01, -1, 0);
    axi_read(8'h04, 16'h0000, 8'd0, 3'd2, 2'b01, 0);
    check("strobe_word", rbeat[0], 32'h00BB00DD);
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    axi_write(8'h05, 16'h0040, 8'd2, 3'd2, 2'b00, -1, 0);
    axi_read(8'h06, 16'h0040, 8'd0, 3'd2, 2'b01, 0);
    check("fixed_final", rbeat[0], 32'h3);
    axi_read(8'h07, 16'h0000, 8'd15, 3'd2, 2'b01, 1);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(8'h08, 16'h0180, 8'd3, 3'd2, 2'b01, -1, 10);
    wd[0] = 32'hA1; wd[1] = 32'hB2; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(8'h09, 16'h0080, 8'd1, 3'd2, 2'b01, 0, 0);
    axi_read(8'h0A, 16'h0080, 8'd1, 3'd2, 2'b01, 0);
    check("wlast_err_beat0", rbeat[0], 32'hA1);
    check("wlast_err_beat1", rbeat[1], 32'hB2);
    s_axi_arid = 8'h0B; s_axi_araddr = 16'h0000; s_axi_arlen = 8'd15; s_axi_arsize = 3'd2; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    check("mid_arready", 32'(s_axi_arready), 32'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rvalid_before", 32'(s_axi_rvalid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("mid_rst_rlast", 32'(s_axi_rlast), 32'd0);
    check("mid_rst_arready", 32'(s_axi_arready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_after_arready", 32'(s_axi_arready), 32'd1);
    s_axi_rready = 1'b0;
    @(posedge clk); #1;
    check("mid_after_rvalid", 32'(s_axi_rvalid), 32'd0);
    axi_read(8'h0C, 16'h0100, 8'd3, 3'd2, 2'b01, 0);
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
    fork
      axi_write(8'h0D, 16'h0200, 8'd7, 3'd2, 2'b01, -1, 2);
      axi_read(8'h0E, 16'h0300, 8'd7, 3'd2, 2'b01, 2);
    join
    axi_read(8'h0F, 16'h0200, 8'd7, 3'd2, 2'b01, 0);
    for (int t = 0; t < 24; t++) begin
      sz = 3'($urandom_range(0, 3));
      bu = 2'($urandom_range(0, 2));
      ln = (bu == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 15));
      ad = 16'($urandom_range(0, 16'h02FF));
      eb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(ln)) : -1;
      for (int i = 0; i <= int'(ln); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      axi_write(8'($urandom), ad, ln, sz, bu, eb, $urandom_range(0, 3));
      axi_read(8'($urandom), ad, ln, sz, bu, $urandom_range(0, 2));
      axi_read(8'($urandom), 16'($urandom_range(0, 16'h02FF)), 8'($urandom_range(0, 15)), 3'd2, 2'b01, 2);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
